// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of the UART receiver: serial line and pop strobe in,
// FIFO head word, flags and occupancy out.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          rx;
  logic                          rd;
  logic [DATA_BITS-1:0]          d;
  logic                          fe;
  logic                          pe;
  logic                          rxne;
  logic                          ovr;
  logic [$clog2(FIFO_DEPTH):0]   count;

  modport slave  (input rx, rd, output d, fe, pe, rxne, ovr, count);
  modport master (output rx, rd, input d, fe, pe, rxne, ovr, count);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 3-sample majority vote, configurable frame
// format and a first-word-fall-through buffer carrying per-word error flags.
module uart_rx_fifo #(
  parameter int CLOCK      = 1_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int DIV_RAW = CLOCK / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int MID     = OVERSAMPLE / 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  typedef struct packed {
    logic                 fe;
    logic                 pe;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  logic [1:0]           sync;
  logic                 rx_s, rx_q, fall;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  state_t               state;
  logic [TW-1:0]        tcnt;
  logic [1:0]           smp;
  logic                 vote, decide, par_exp;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bidx;
  logic                 sidx;
  logic                 fe_acc, pe_acc;
  logic                 push;
  entry_t               push_word;

  assign rx_s = sync[1];
  assign fall = rx_q & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      rx_q <= 1'b1;
    end else begin
      sync <= {sync[0], bus.rx};
      rx_q <= rx_s;
    end
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // Two early samples are registered; the third is the live line at decision time.
  assign vote    = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign decide  = tick && (tcnt == TW'(MID + 1)) && (state != S_IDLE);
  assign par_exp = (PARITY == 1) ? ~(^shreg) : (^shreg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      smp       <= 2'b11;
      shreg     <= '0;
      bidx      <= '0;
      sidx      <= 1'b0;
      fe_acc    <= 1'b0;
      pe_acc    <= 1'b0;
      push      <= 1'b0;
      push_word <= '0;
    end else begin
      push <= 1'b0;
      if (state == S_IDLE) tcnt <= '0;
      else if (tick)       tcnt <= (tcnt == TW'(OVERSAMPLE - 1)) ? '0 : tcnt + 1'b1;
      if (tick && tcnt == TW'(MID - 1)) smp[0] <= rx_s;
      if (tick && tcnt == TW'(MID))     smp[1] <= rx_s;
      case (state)
        // A held-low line gives no falling edge, so a break re-arms only after RX goes high.
        S_IDLE: if (fall) begin
          state  <= S_START;
          fe_acc <= 1'b0;
          pe_acc <= 1'b0;
        end
        S_START: if (decide) begin
          if (vote) state <= S_IDLE;
          else begin
            state <= S_DATA;
            bidx  <= '0;
          end
        end
        S_DATA: if (decide) begin
          shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (bidx == BW'(DATA_BITS - 1)) begin
            state <= (PARITY != 0) ? S_PARITY : S_STOP;
            sidx  <= 1'b0;
          end else begin
            bidx <= bidx + 1'b1;
          end
        end
        S_PARITY: if (decide) begin
          pe_acc <= vote ^ par_exp;
          state  <= S_STOP;
          sidx   <= 1'b0;
        end
        S_STOP: if (decide) begin
          fe_acc <= fe_acc | ~vote;
          if (sidx == 1'(STOP_BITS - 1)) begin
            push      <= 1'b1;
            push_word <= {fe_acc | ~vote, pe_acc, shreg};
            state     <= S_IDLE;
          end else begin
            sidx <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          ovr_r, full, pop, wr;

  assign full = (cnt == CW'(FIFO_DEPTH));
  assign pop  = bus.rd && (cnt != '0);
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovr_r <= 1'b0;
    end else begin
      if (wr) begin
        mem[wptr] <= push_word;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A fresh overrun in the same cycle as a clearing read keeps the flag set.
      if (push && full && !pop) ovr_r <= 1'b1;
      else if (pop)             ovr_r <= 1'b0;
    end
  end

  assign bus.d     = mem[rptr].data;
  assign bus.fe    = mem[rptr].fe;
  assign bus.pe    = mem[rptr].pe;
  assign bus.rxne  = (cnt != '0);
  assign bus.ovr   = ovr_r;
  assign bus.count = cnt;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance, table-driven
// frames plus hand sequences for break, glitch, overrun and mid-frame reset.
module tb_uart_rx_fifo;
  localparam int CLOCK = 3_686_400;
  localparam int BAUD  = 115_200;
  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int BIT   = 32;
  localparam int NV    = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if0 ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if1 ();

  uart_rx_fifo #(.CLOCK(CLOCK), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH))
    u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  uart_rx_fifo #(.CLOCK(CLOCK), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH))
    u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    logic       fe;
    logic       pe;
  } vec_t;

  ent_t sb0[$];
  ent_t sb1[$];
  vec_t vt[NV];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic int f_d(input int inst);    return inst == 0 ? int'(if0.d)     : int'(if1.d);     endfunction
  function automatic int f_fe(input int inst);   return inst == 0 ? int'(if0.fe)    : int'(if1.fe);    endfunction
  function automatic int f_pe(input int inst);   return inst == 0 ? int'(if0.pe)    : int'(if1.pe);    endfunction
  function automatic int f_rxne(input int inst); return inst == 0 ? int'(if0.rxne)  : int'(if1.rxne);  endfunction
  function automatic int f_ovr(input int inst);  return inst == 0 ? int'(if0.ovr)   : int'(if1.ovr);   endfunction
  function automatic int f_cnt(input int inst);  return inst == 0 ? int'(if0.count) : int'(if1.count); endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int inst, input logic b, input int n);
    if (inst == 0) if0.rx = b; else if1.rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int inst, input logic [7:0] data,
                            input logic bad_par, input logic stop);
    drive_bit(inst, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(inst, data[i], BIT);
    if (inst == 1) drive_bit(inst, (^data) ^ bad_par, BIT);
    drive_bit(inst, stop, BIT);
    if (inst == 0) if0.rx = 1'b1; else if1.rx = 1'b1;
  endtask

  task automatic expect_word(input int inst, input ent_t e);
    if (inst == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  task automatic wait_rxne(input int inst, input int budget, input string name);
    int k = 0;
    while (f_rxne(inst) == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, f_rxne(inst), 1);
  endtask

  // Compare the FIFO head with the oldest expected word, then pop it.
  task automatic pop_check(input int inst, input string name);
    ent_t e;
    if ((inst == 0 ? sb0.size() : sb1.size()) == 0) begin
      check({name, "_scoreboard_empty"}, 1, 0);
      return;
    end
    e = (inst == 0) ? sb0.pop_front() : sb1.pop_front();
    check({name, "_d"},  f_d(inst),  int'(e.data));
    check({name, "_fe"}, f_fe(inst), int'(e.fe));
    check({name, "_pe"}, f_pe(inst), int'(e.pe));
    if (inst == 0) if0.rd = 1'b1; else if1.rd = 1'b1;
    @(negedge clk);
    if (inst == 0) if0.rd = 1'b0; else if1.rd = 1'b0;
  endtask

  initial begin
    bit exp_ovr;
    if0.rx = 1'b1; if0.rd = 1'b0;
    if1.rx = 1'b1; if1.rd = 1'b0;

    vt[0] = '{0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1, 8'h37, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[2] = '{1, 8'h37, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4] = '{0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_d",    f_d(0),    0);
    check("rst_fe",   f_fe(0),   0);
    check("rst_pe",   f_pe(1),   0);
    check("rst_rxne", f_rxne(0), 0);
    check("rst_ovr",  f_ovr(0),  0);
    check("rst_cnt",  f_cnt(1),  0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // 8N1 0xA5 with a coarse window on push latency inside the stop bit
    drive_bit(0, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(0, (8'hA5 >> i) & 8'h1, BIT);
    drive_bit(0, 1'b1, 12);
    check("a5_rxne_early", f_rxne(0), 0);
    drive_bit(0, 1'b1, 20);
    check("a5_rxne", f_rxne(0), 1);
    expect_word(0, '{1'b0, 1'b0, 8'hA5});
    check("a5_cnt", f_cnt(0), 1);
    pop_check(0, "a5");
    check("a5_rxne_after_rd", f_rxne(0), 0);
    check("a5_cnt_after_rd",  f_cnt(0),  0);
    drive_bit(0, 1'b1, BIT);

    for (int i = 0; i < NV; i++) begin
      send_frame(vt[i].inst, vt[i].data, vt[i].bad_par, vt[i].stop);
      expect_word(vt[i].inst, '{vt[i].fe, vt[i].pe, vt[i].data});
      wait_rxne(vt[i].inst, 64, $sformatf("vec%0d_rxne", i));
      check($sformatf("vec%0d_cnt", i), f_cnt(vt[i].inst), 1);
      pop_check(vt[i].inst, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_empty", i), f_rxne(vt[i].inst), 0);
      drive_bit(vt[i].inst, 1'b1, BIT);
    end

    // break: one zero word with FE, nothing more until the line idles high
    drive_bit(0, 1'b0, 40 * BIT);
    expect_word(0, '{1'b1, 1'b0, 8'h00});
    check("brk_cnt", f_cnt(0), 1);
    drive_bit(0, 1'b1, 3 * BIT);
    check("brk_cnt_after_idle", f_cnt(0), 1);
    pop_check(0, "brk");
    check("brk_cnt_after_rd", f_cnt(0), 0);

    // short low glitch must not store anything; a real frame must follow cleanly
    drive_bit(0, 1'b0, 6);
    drive_bit(0, 1'b1, 3 * BIT);
    check("glitch_cnt",  f_cnt(0),  0);
    check("glitch_rxne", f_rxne(0), 0);
    send_frame(0, 8'h96, 1'b0, 1'b1);
    expect_word(0, '{1'b0, 1'b0, 8'h96});
    wait_rxne(0, 64, "glitch_next_rxne");
    pop_check(0, "glitch_next");
    drive_bit(0, 1'b1, BIT);

    // overrun: five back-to-back frames into a four-deep buffer
    exp_ovr = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(0, 8'(v), 1'b0, 1'b1);
      if (sb0.size() < DEPTH) expect_word(0, '{1'b0, 1'b0, 8'(v)});
      else                    exp_ovr = 1'b1;
    end
    drive_bit(0, 1'b1, BIT);
    check("ovr_cnt  ", f_cnt(0), sb0.size());
    check("ovr_flag", f_ovr(0), int'(exp_ovr));
    for (int k = 0; k < DEPTH; k++) begin
      pop_check(0, $sformatf("ovr_rd%0d", k));
      if (k == 0) check("ovr_cleared", f_ovr(0), 0);
    end
    check("ovr_cnt_end", f_cnt(0), 0);
    drive_bit(0, 1'b1, BIT);

    // reset in the middle of a data bit of 0xFF, with a word already buffered
    send_frame(0, 8'h77, 1'b0, 1'b1);
    expect_word(0, '{1'b0, 1'b0, 8'h77});
    drive_bit(0, 1'b1, BIT);
    check("pre_rst_rxne", f_rxne(0), 1);
    drive_bit(0, 1'b0, BIT);
    drive_bit(0, 1'b1, 2 * BIT + 10);
    rst = 1'b1;
    sb0.delete();
    @(negedge clk);
    check("mid_rst_rxne", f_rxne(0), 0);
    check("mid_rst_cnt",  f_cnt(0),  0);
    check("mid_rst_d",    f_d(0),    0);
    check("mid_rst_fe",   f_fe(0),   0);
    drive_bit(0, 1'b1, 20);
    rst = 1'b0;
    drive_bit(0, 1'b1, 7 * BIT);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    expect_word(0, '{1'b0, 1'b0, 8'h3C});
    drive_bit(0, 1'b1, BIT);
    check("post_rst_cnt", f_cnt(0), 1);
    pop_check(0, "post_rst");
    check("post_rst_cnt_end", f_cnt(0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver in the UART echo path. Frame format is configurable: data width, parity and stop bits. Each bit is oversampled and decided by a 3-sample majority vote. Received words and their error flags are buffered in a small first-word-fall-through FIFO, with framing, parity and overrun reporting. It sits between the board RX pin and the echo/memory logic, which drains it with RD.

Parameters:
CLOCK, 1_000_000, system clock frequency in Hz
BAUD_RATE, 9_600, line rate in baud
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits checked (1 or 2)
OVERSAMPLE, 16, ticks per bit (even, >=8)
FIFO_DEPTH, 4, word buffer depth (power of 2, >=2)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset; asynchronous and active-high
RX  in  1  serial line, idle high, asynchronous to CLK
RD  in  1  pop strobe; one word per cycle high
D  out  DATA_BITS  data word at FIFO head
FE  out  1  framing error of head word
PE  out  1  parity error of head word (0 when PARITY=0)
RXNE  out  1  FIFO not empty; D/FE/PE valid
OVR  out  1  sticky overrun flag
COUNT  out  $clog2(FIFO_DEPTH)+1  words held

Behaviour:
- Reset, asynchronous and active-high: D=0, FE=0, PE=0, RXNE=0, OVR=0, COUNT=0; FSM=IDLE; FIFO pointers 0; synchroniser and sample registers = 1.
- Reset mid-frame aborts the frame and discards the partial word.
- RX passes through a 2-FF synchroniser before any use.
- Tick generator: DIV = CLOCK/(BAUD_RATE*OVERSAMPLE), integer truncated, minimum 1. A 1-cycle tick pulse is produced every DIV clocks, free-running from reset.
- A bit sample is the majority of the synchronised RX at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit. The bit decision is taken at tick OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a synchronised 1->0 transition, clear the tick counter and go to START.
  - START: at the decision point, majority 1 means a glitch: go to IDLE, nothing is stored. Majority 0 goes to DATA, bit index 0.
  - DATA: shift in DATA_BITS samples, LSB first, one every OVERSAMPLE ticks. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: PE = received parity bit differs from the odd/even parity computed over the data bits.
  - STOP: sample STOP_BITS bits; any sample 0 sets FE. After the last stop decision, push {FE, PE, data} and go to IDLE immediately. This allows back-to-back frames whose start edge arrives half a bit later.
- Push latency: the word appears at D, with RXNE=1, on the clock after the final stop decision.
- FIFO is first-word-fall-through. D/FE/PE always show the head entry; they are undefined-but-stable when empty (hold the last value).
- RD with RXNE=1: pop; the next entry appears the following cycle. RD with RXNE=0: ignored.
- Push with COUNT=FIFO_DEPTH and no simultaneous pop: the word is dropped and OVR is set. Stored words are unchanged.
- Push and pop in the same cycle while full: both happen, COUNT is unchanged, no overrun.
- OVR is cleared by any RD while RXNE=1. If a new overrun occurs in the same cycle, set wins.
- COUNT increments on push, decrements on pop, and is unchanged on simultaneous push+pop.
- Pointers wrap modulo FIFO_DEPTH.
- A frame with FE=1 is still stored. A break condition (RX held low) yields one word of 0 with FE=1. The FSM then waits in IDLE for RX to return high before arming the next edge.

Test Plan:
Bench parameters: CLOCK=3_686_400, BAUD_RATE=115_200, OVERSAMPLE=16, so DIV=2 and one bit period is 32 clocks.
1. 8N1, send 0xA5 -> RXNE rises 1 clk after the stop decision; D=0xA5, FE=0, PE=0, COUNT=1. RD pulse -> RXNE=0, COUNT=0.
2. PARITY=2, send 0x37 with the parity bit inverted -> D=0x37, PE=1. Resend with correct parity -> PE=0.
3. Stop bit driven 0 for 0x5A -> D=0x5A, FE=1. A 40-bit-period break -> exactly one word, D=0x00, FE=1, and no new frame until RX returns high.
4. Low glitch of 6 clocks on an idle line -> no word stored, FSM back in IDLE, COUNT=0.
5. FIFO_DEPTH=4, send 0x01..0x05 back-to-back without RD -> COUNT=4, OVR=1. Reading gives 0x01,0x02,0x03,0x04; OVR clears on the first RD; 0x05 is lost.
6. Assert RST mid-data-bit of 0xFF, release, then send 0x3C -> outputs at reset values during RST; only 0x3C is received, COUNT=1.
